// File: rtl/membrane_accum.sv
// Membrane potential accumulator: a flop array of N signed potentials.
// Synapse events add LANES packed signed weights to one neuron group
// through a one-deep stage-1 register. An IDLE/CLEAR sweep zeroes the
// array one group per cycle. Reads are combinational, RD_LANES potentials
// per 32-bit word.
module membrane_accum #(
    parameter int unsigned N        = 256,
    parameter int unsigned W_BITS   = 4,
    parameter int unsigned POT_BITS = 8,
    parameter int unsigned SAT      = 1,
    localparam int unsigned LANES    = 32 / W_BITS,
    localparam int unsigned RD_LANES = 32 / POT_BITS,
    localparam int unsigned NGRP     = N / LANES,
    localparam int unsigned RGRP     = N / RD_LANES,
    localparam int unsigned AW       = $clog2(NGRP),
    localparam int unsigned RAW      = $clog2(RGRP)
) (
    input  logic           CLK,
    input  logic           RSTN,
    input  logic           syn_valid_i,
    output logic           syn_ready_o,
    input  logic [AW-1:0]  syn_addr_i,
    input  logic [31:0]    syn_data_i,
    input  logic           clear_i,
    output logic           busy_o,
    output logic           clear_done_o,
    output logic           ovf_o,
    input  logic [RAW-1:0] rd_addr_i,
    output logic [31:0]    rd_data_o
);

    // Lane-select bits inside a group (LANES and RD_LANES are powers of two).
    localparam int unsigned LB  = $clog2(LANES);
    localparam int unsigned RLB = $clog2(RD_LANES);

    localparam logic [POT_BITS-1:0] MaxPot = {1'b0, {(POT_BITS - 1){1'b1}}};
    localparam logic [POT_BITS-1:0] MinPot = {1'b1, {(POT_BITS - 1){1'b0}}};

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e        state_q;
    logic [AW-1:0] grp_q;
    logic          busy_q;
    logic          done_q;
    logic          ovf_q;

    logic          s1_valid_q;
    logic [AW-1:0] s1_addr_q;
    logic [31:0]   s1_data_q;

    logic [POT_BITS-1:0] pot_q [N];
    logic [POT_BITS-1:0] pot_d [N];

    logic [POT_BITS-1:0] lane_res [LANES];
    logic [LANES-1:0]    lane_ovf;

    logic                syn_accept;

    // New events are refused while sweeping or while a sweep is being requested.
    always_comb begin
        syn_ready_o = (state_q == StIdle) && !clear_i;
        syn_accept  = syn_valid_i && syn_ready_o;
    end

    // Stage 1: capture the accepted event; it is applied on the following edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= syn_accept;
            if (syn_accept) begin
                s1_addr_q <= syn_addr_i;
                s1_data_q <= syn_data_i;
            end
        end
    end

    // Per-lane add at POT_BITS+1 bits with overflow detect and optional clamp.
    always_comb begin
        logic [POT_BITS-1:0] cur;
        logic [W_BITS-1:0]   w;
        logic [POT_BITS:0]   sum;
        cur      = '0;
        w        = '0;
        sum      = '0;
        lane_ovf = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_res[k] = '0;
        end
        for (int k = 0; k < LANES; k++) begin
            cur = pot_q[{s1_addr_q, LB'(k)}];
            w   = s1_data_q[k*W_BITS +: W_BITS];
            sum = {cur[POT_BITS-1], cur}
                + {{(POT_BITS + 1 - W_BITS){w[W_BITS-1]}}, w};
            // The two top bits disagree exactly when the result left POT_BITS range.
            lane_ovf[k] = sum[POT_BITS] ^ sum[POT_BITS-1];
            if (lane_ovf[k] && (SAT != 0)) begin
                lane_res[k] = sum[POT_BITS] ? MinPot : MaxPot;
            end else begin
                lane_res[k] = sum[POT_BITS-1:0];
            end
        end
    end

    // Next potentials: apply the stage-1 update, then let the sweep override it.
    always_comb begin
        pot_d = pot_q;
        for (int g = 0; g < NGRP; g++) begin
            for (int k = 0; k < LANES; k++) begin
                if (s1_valid_q && (s1_addr_q == AW'(g))) begin
                    pot_d[g*LANES + k] = lane_res[k];
                end
                if ((state_q == StClear) && (grp_q == AW'(g))) begin
                    pot_d[g*LANES + k] = '0;
                end
            end
        end
    end

    // Potential array; reset zeroes everything asynchronously.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < N; i++) begin
                pot_q[i] <= '0;
            end
        end else begin
            pot_q <= pot_d;
        end
    end

    // Sweep FSM with registered busy, done pulse and sticky overflow.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= StIdle;
            grp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (clear_i) begin
                        // A pending update still lands this edge; the sweep erases it.
                        state_q <= StClear;
                        grp_q   <= '0;
                        busy_q  <= 1'b1;
                        ovf_q   <= 1'b0;
                    end else if (s1_valid_q && (|lane_ovf)) begin
                        ovf_q <= 1'b1;
                    end
                end
                StClear: begin
                    // clear_i is deliberately not looked at here.
                    if (grp_q == AW'(NGRP - 1)) begin
                        state_q <= StIdle;
                        grp_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        grp_q <= grp_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Status outputs straight from their registers.
    always_comb begin
        busy_o       = busy_q;
        clear_done_o = done_q;
        ovf_o        = ovf_q;
    end

    // Combinational read port, RD_LANES potentials per word.
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < RD_LANES; k++) begin
            rd_data_o[k*POT_BITS +: POT_BITS] = pot_q[{rd_addr_i, RLB'(k)}];
        end
    end

endmodule

// File: tb/tb_membrane_accum.sv
// Directed bench for membrane_accum: a saturating instance and a wrapping
// instance share all stimulus; expected values are hand-computed constants.
module tb_membrane_accum;

    logic        clk;
    logic        rstn;
    logic        syn_valid;
    logic [4:0]  syn_addr;
    logic [31:0] syn_data;
    logic        clear;
    logic [5:0]  rd_addr;

    logic        ready_s, busy_s, done_s, ovf_s;
    logic [31:0] rd_s;
    logic        ready_w, busy_w, done_w, ovf_w;
    logic [31:0] rd_w;

    int n_total;
    int n_bad;
    int stall_cnt;

    membrane_accum #(.N(256), .W_BITS(4), .POT_BITS(8), .SAT(1)) u_dut_sat (
        .CLK          (clk),
        .RSTN         (rstn),
        .syn_valid_i  (syn_valid),
        .syn_ready_o  (ready_s),
        .syn_addr_i   (syn_addr),
        .syn_data_i   (syn_data),
        .clear_i      (clear),
        .busy_o       (busy_s),
        .clear_done_o (done_s),
        .ovf_o        (ovf_s),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_s)
    );

    membrane_accum #(.N(256), .W_BITS(4), .POT_BITS(8), .SAT(0)) u_dut_wrap (
        .CLK          (clk),
        .RSTN         (rstn),
        .syn_valid_i  (syn_valid),
        .syn_ready_o  (ready_w),
        .syn_addr_i   (syn_addr),
        .syn_data_i   (syn_data),
        .clear_i      (clear),
        .busy_o       (busy_w),
        .clear_done_o (done_w),
        .ovf_o        (ovf_w),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] a, input logic [31:0] d);
        syn_valid = 1'b1;
        syn_addr  = a;
        syn_data  = d;
        if (!ready_s) stall_cnt++;
        tick();
        syn_valid = 1'b0;
    endtask

    task automatic do_reset();
        #1;
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        #1;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] ds, output logic [31:0] dw);
        rd_addr = a;
        #1;
        ds = rd_s;
        dw = rd_w;
    endtask

    task automatic chk_zero(input string tag);
        logic [31:0] acc_s, acc_w, ds, dw;
        acc_s = '0;
        acc_w = '0;
        for (int i = 0; i < 64; i++) begin
            rd(6'(i), ds, dw);
            acc_s |= ds;
            acc_w |= dw;
        end
        chk({tag, "_sat"}, acc_s, 32'h0);
        chk({tag, "_wrap"}, acc_w, 32'h0);
    endtask

    initial begin
        logic [31:0] ds, dw;
        int cyc;
        int ready_bad;
        int done_seen;

        n_total   = 0;
        n_bad     = 0;
        stall_cnt = 0;
        rstn      = 1'b0;
        syn_valid = 1'b0;
        syn_addr  = '0;
        syn_data  = '0;
        clear     = 1'b0;
        rd_addr   = '0;

        // Reset release
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        chk("rst_ready", ready_s, 1);
        chk("rst_busy", busy_s, 0);
        chk("rst_ovf", ovf_s, 0);
        chk("rst_done", done_s, 0);
        chk_zero("rst_zero");

        // Single event: two edges from acceptance to visibility
        tick();
        send(5'd2, 32'h8765_4321);
        rd(6'd4, ds, dw);
        chk("single_latency", ds, 32'h0);
        tick();
        rd(6'd4, ds, dw);
        chk("single_rd4", ds, 32'h0403_0201);
        rd(6'd5, ds, dw);
        chk("single_rd5", ds, 32'hF807_0605);
        chk("single_rd5_wrap", dw, 32'hF807_0605);
        chk("single_ovf", ovf_s, 0);

        // Back-to-back events to one group
        do_reset();
        stall_cnt = 0;
        for (int i = 0; i < 4; i++) send(5'd0, 32'h1111_1111);
        tick();
        chk("b2b_stall", stall_cnt, 0);
        rd(6'd0, ds, dw);
        chk("b2b_rd0", ds, 32'h0404_0404);
        rd(6'd1, ds, dw);
        chk("b2b_rd1", ds, 32'h0404_0404);

        // Positive saturation / wrap
        do_reset();
        for (int i = 0; i < 18; i++) send(5'd0, 32'h0000_0007);
        tick();
        rd(6'd0, ds, dw);
        chk("satp_18", ds, 32'h0000_007E);
        chk("satp_18_ovf", ovf_s, 0);
        send(5'd0, 32'h0000_0007);
        tick();
        rd(6'd0, ds, dw);
        chk("satp_19", ds, 32'h0000_007F);
        chk("satp_19_ovf", ovf_s, 1);
        chk("wrapp_19", dw, 32'h0000_0085);
        chk("wrapp_19_ovf", ovf_w, 1);
        send(5'd0, 32'h0000_0007);
        tick();
        rd(6'd0, ds, dw);
        chk("satp_20", ds, 32'h0000_007F);
        chk("wrapp_20", dw, 32'h0000_008C);

        // Negative saturation / wrap
        do_reset();
        for (int i = 0; i < 16; i++) send(5'd0, 32'h0000_0008);
        tick();
        rd(6'd0, ds, dw);
        chk("satn_16", ds, 32'h0000_0080);
        chk("satn_16_ovf", ovf_s, 0);
        send(5'd0, 32'h0000_0008);
        tick();
        rd(6'd0, ds, dw);
        chk("satn_17", ds, 32'h0000_0080);
        chk("satn_17_ovf", ovf_s, 1);
        chk("wrapn_17", dw, 32'h0000_0078);
        chk("wrapn_17_ovf", ovf_w, 1);

        // Clear sweep, with an event accepted just before clear_i
        send(5'd3, 32'h1111_1111);
        clear = 1'b1;
        #1;
        chk("clr_req_ready", ready_s, 0);
        tick();
        clear = 1'b0;
        cyc       = 0;
        ready_bad = 0;
        while (busy_s && cyc < 40) begin
            if (ready_s) ready_bad++;
            clear = (cyc == 5);
            tick();
            cyc++;
        end
        clear = 1'b0;
        chk("clr_cycles", cyc, 32);
        chk("clr_ready_low", ready_bad, 0);
        chk("clr_done", done_s, 1);
        chk("clr_ovf", ovf_s, 0);
        chk("clr_ovf_wrap", ovf_w, 0);
        tick();
        chk("clr_done_pulse", done_s, 0);
        chk("clr_ready_after", ready_s, 1);
        chk_zero("clr_zero");

        // Reset with an event sitting in stage 1
        tick();
        send(5'd1, 32'h1111_1111);
        do_reset();
        tick();
        tick();
        chk_zero("rst_s1_zero");

        // Reset in the middle of a sweep
        tick();
        send(5'd20, 32'h1111_1111);
        send(5'd31, 32'h2222_2222);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (10) tick();
        chk("midclr_busy_pre", busy_s, 1);
        do_reset();
        chk("midclr_busy", busy_s, 0);
        chk("midclr_ready", ready_s, 1);
        chk_zero("midclr_zero");
        done_seen = 0;
        repeat (40) begin
            tick();
            if (done_s || busy_s) done_seen++;
        end
        chk("midclr_no_done", done_seen, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/membrane_accum.md
MEMBRANE_ACCUM -- requirements
Module: membrane_accum

Interface
REQ-001 SHALL have parameter N, default 256, neuron count; N divisible by LANES and RD_LANES.
REQ-002 SHALL have parameter W_BITS, default 4, signed weight width; valid values 1, 2, 4, 8.
REQ-003 SHALL have parameter POT_BITS, default 8, signed potential width; valid values 8, 16; POT_BITS > W_BITS.
REQ-004 SHALL have parameter SAT, default 1: 1 = saturating accumulate, 0 = two's-complement wrap.
REQ-005 SHALL derive LANES = 32/W_BITS (weights per event) and RD_LANES = 32/POT_BITS (potentials per read word).
REQ-006 SHALL have the following ports:
- CLK  in  1  clock.
- RSTN  in  1  reset, asynchronous, active-low.
- syn_valid_i  in  1  synapse event valid.
- syn_ready_o  out  1  event accepted when syn_valid_i & syn_ready_o.
- syn_addr_i  in  clog2(N/LANES)  neuron group index.
- syn_data_i  in  32  LANES packed weights; lane k = bits [k*W_BITS +: W_BITS].
- clear_i  in  1  start-clear pulse.
- busy_o  out  1  clear sweep in progress.
- clear_done_o  out  1  one-cycle pulse at sweep end.
- ovf_o  out  1  sticky overflow flag.
- rd_addr_i  in  clog2(N/RD_LANES)  read group index.
- rd_data_o  out  32  potential of neuron rd_addr_i*RD_LANES+k in bits [k*POT_BITS +: POT_BITS].

Function
REQ-007 SHALL hold N signed POT_BITS potentials in flops.
REQ-008 SHALL register accepted addr/data in stage 1 at the acceptance edge and update potentials at the next edge: 2-edge latency from acceptance to rd_data_o.
REQ-009 SHALL add each lane's sign-extended weight k to neuron syn_addr*LANES+k; all LANES updates occur in one cycle.
REQ-010 SHALL accept one event per cycle, with back-to-back events to the same group accumulating without loss or stall.
REQ-011 SHALL form sums at POT_BITS+1 bits; on overflow with SAT=1, clamp to +2^(POT_BITS-1)-1 or -2^(POT_BITS-1); with SAT=0, keep the low POT_BITS bits.
REQ-012 SHALL set ovf_o on any lane overflow under either SAT setting; ovf_o stays set until reset or sweep start.
REQ-013 SHALL drive rd_data_o combinationally from the potential array.
REQ-014 SHALL use an FSM with states IDLE and CLEAR; IDLE->CLEAR on clear_i; CLEAR->IDLE after the last group.
REQ-015 SHALL zero one group of LANES neurons per cycle in CLEAR, group 0 first, taking N/LANES cycles; busy_o=1 throughout.
REQ-016 SHALL drive syn_ready_o = (state==IDLE) & !clear_i.
REQ-017 SHALL perform a stage-1 update pending at the IDLE->CLEAR edge normally, after which the sweep zeroes it.
REQ-018 SHALL ignore clear_i while in CLEAR.
REQ-019 SHALL clear ovf_o on the IDLE->CLEAR edge.
REQ-020 SHALL pulse clear_done_o for the first IDLE cycle after the sweep.

Reset
REQ-021 SHALL, on RSTN low, asynchronously set all potentials to 0, stage-1 valid to 0, FSM to IDLE, and ovf_o, busy_o and clear_done_o to 0; syn_ready_o then reads 1.
REQ-022 SHALL, on reset during CLEAR or with an event in stage 1, abort the sweep and drop the event, leaving no partial state after release.

Verification (defaults N=256, W_BITS=4, POT_BITS=8)
REQ-023 SHALL cover reset release: all 64 read words = 0x00000000, syn_ready_o=1, busy_o=0, ovf_o=0.
REQ-024 SHALL cover a single event, addr 2, data 0x87654321: after 2 edges rd_addr 4 -> 0x04030201 and rd_addr 5 -> 0xF8070605.
REQ-025 SHALL cover back-to-back: 4 consecutive events, addr 0, data 0x11111111: rd_addr 0 and 1 -> 0x04040404, no stall.
REQ-026 SHALL cover saturation: 20 events, addr 0, data 0x00000007 (SAT=1): neuron 0 = 0x7F and ovf_o=1 after the 19th update; 17 events with data 0x00000008: neuron 0 = 0x80, ovf_o=1; with SAT=0, 19 events of 7 give 0x85.
REQ-027 SHALL cover clear: clear_i pulse -> busy_o=1 and syn_ready_o=0 for 32 cycles, then clear_done_o one cycle, all words 0, ovf_o=0; an event accepted the cycle before clear_i is also zeroed.
REQ-028 SHALL cover reset mid-clear: RSTN low at sweep group 10 -> after release, IDLE, busy_o=0, all words 0, no clear_done_o pulse.
